pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). Inputs:
- ID-stage opcode and source registers.
- EX-stage load and branch-resolution info (pc_src from the decode control).
- Data-memory handshake from MEM.

It produces per-stage enable and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. A small FSM tracks outstanding data-memory waits, with a timeout to a sticky error state.

---
 rtl/pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and data-memory wait handling.
// Optional stall/flush performance counters are enabled by defining PIPELINE_HAZARD_CTRL_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_pc_src,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [1:0]       ctrl_state
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
   ,output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
`endif
);

    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt, next_cnt, cnt_inc;
    logic              uses_rs1, uses_rs2, load_use, mem_stall;
    logic              kill, stall, go, br_flush;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b0010011, 7'b0000011:             uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use  = ex_mem_read && (ex_rd != '0) &&
                       ((uses_rs1 && ex_rd == id_rs1) || (uses_rs2 && ex_rd == id_rs2));
    assign mem_stall = mem_req && !dmem_ready;
    assign cnt_inc   = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

    // Decide the cycle's mode and next state, then derive strobes from the mode.
    always_comb begin
        kill       = 1'b0;
        stall      = 1'b0;
        go         = 1'b0;
        mem_err    = 1'b0;
        next_state = state;
        next_cnt   = wait_cnt;
        if (rst) begin
            kill       = 1'b1;
            next_state = RUN;
            next_cnt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        stall      = 1'b1;
                        next_state = MEM_WAIT;
                        next_cnt   = WAIT_W'(1);
                    end else begin
                        go = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        stall    = 1'b1;
                        next_cnt = cnt_inc;
                        // cnt_inc counts this cycle, so the error lands after MEM_TIMEOUT wait cycles
                        if (MEM_TIMEOUT != 0 && cnt_inc >= TIMEOUT_V)
                            next_state = ERROR;
                    end else begin
                        go         = 1'b1;
                        next_state = RUN;
                        next_cnt   = '0;
                    end
                end
                default: begin
                    kill    = 1'b1;
                    mem_err = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;
        br_flush    = 1'b0;
        if (kill) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (go) begin
            // A taken branch squashes the dependent instruction, so load-use is moot.
            if (ex_pc_src) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                br_flush   = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
        end
    end

    assign ctrl_state = state;

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (br_flush && flush_count != '1)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, hand sequences and a randomized reference model.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_read, ex_pc_src, mem_req, dmem_ready;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, mem_err;
    logic [1:0] ctrl_state;
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    pipeline_hazard_ctrl #(.REG_W(5), .WAIT_W(8), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_pc_src(ex_pc_src),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
        .mem_err(mem_err), .ctrl_state(ctrl_state)
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
       ,.stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
    localparam logic [6:0] S_DEF  = 7'b1101010;
    localparam logic [6:0] S_LU   = 7'b0001110;
    localparam logic [6:0] S_BR   = 7'b1111110;
    localparam logic [6:0] S_STL  = 7'b0000001;
    localparam logic [6:0] S_KILL = 7'b0010101;

    logic [6:0] strb;
    assign strb = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic mr, input logic [4:0] rd, input logic br, input logic mq, input logic dr);
        rst = r; id_opcode = op; id_rs1 = r1; id_rs2 = r2;
        ex_mem_read = mr; ex_rd = rd; ex_pc_src = br; mem_req = mq; dmem_ready = dr;
        #1;
    endtask

    task automatic idle(input logic r);
        drive(r, 7'b0010011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       mr, br, mq, dr;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // Reference model: pipeline mode 0 run, 1 waiting on memory, 2 error.
    int          m_mode, m_waited;
    longint      m_stalls, m_flushes;

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    endfunction
    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    task automatic model_step(output logic [6:0] e_strb, output logic e_err, output int n_mode, output int n_waited);
        bit hazard;
        hazard = ex_mem_read && ex_rd != 0 &&
                 ((reads_rs1(id_opcode) && ex_rd == id_rs1) || (reads_rs2(id_opcode) && ex_rd == id_rs2));
        e_err = 1'b0;
        n_mode = m_mode;
        n_waited = m_waited;
        if (rst) begin
            e_strb = S_KILL; n_mode = 0; n_waited = 0;
        end else if (m_mode == 2) begin
            e_strb = S_KILL; e_err = 1'b1;
        end else if (!dmem_ready && (m_mode == 1 || mem_req)) begin
            e_strb = S_STL;
            n_waited = (m_mode == 0) ? 1 : ((m_waited + 1 > 255) ? 255 : m_waited + 1);
            n_mode = (m_mode == 1 && n_waited >= TMO) ? 2 : 1;
        end else begin
            e_strb = ex_pc_src ? S_BR : (hazard ? S_LU : S_DEF);
            n_mode = 0; n_waited = 0;
        end
    endtask

    initial begin
        logic [6:0] es;
        logic       ee;
        int         nm, nw;

        // Reset: strobes forced regardless of the unknown initial state.
        idle(1'b1);
        chk("reset_strobes", 32'(strb), 32'(S_KILL));
        chk("reset_err", 32'(mem_err), 32'd0);
        tick;
        idle(1'b1);
        chk("reset_state", 32'(ctrl_state), 32'd0);
        tick;

        // Perf scenario: 2 load-use stalls, a 3-cycle memory wait, 1 branch.
        drive(1'b0, 7'b0110011, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); tick;
        drive(1'b0, 7'b0000011, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); tick;
        drive(1'b0, 7'b0010011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); tick;
        tick; tick;
        drive(1'b0, 7'b0010011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); tick;
        drive(1'b0, 7'b0010011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); tick;
        idle(1'b0);
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
        chk("perf_stall_cycles", stall_cycles, 32'd5);
        chk("perf_flush_count", flush_count, 32'd1);
`endif
        chk("perf_seq_state", 32'(ctrl_state), 32'd0);

        // Single-cycle hazard table, applied from RUN.
        vecs.push_back('{7'b0110011, 5'd1, 5'd5, 5'd5, 1, 0, 0, 0, S_LU,  "lu_rtype_rs2"});
        vecs.push_back('{7'b0110011, 5'd1, 5'd5, 5'd0, 1, 0, 0, 0, S_DEF, "lu_rd_zero"});
        vecs.push_back('{7'b0110011, 5'd1, 5'd5, 5'd5, 1, 1, 0, 0, S_BR,  "branch_over_lu"});
        vecs.push_back('{7'b0010011, 5'd3, 5'd5, 5'd5, 1, 0, 0, 0, S_DEF, "itype_rs2_ignored"});
        vecs.push_back('{7'b0010011, 5'd5, 5'd3, 5'd5, 1, 0, 0, 0, S_LU,  "itype_rs1"});
        vecs.push_back('{7'b0110111, 5'd5, 5'd5, 5'd5, 1, 0, 0, 0, S_DEF, "lui_no_regs"});
        vecs.push_back('{7'b0100011, 5'd2, 5'd9, 5'd9, 1, 0, 0, 0, S_LU,  "store_rs2"});
        vecs.push_back('{7'b0110011, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, S_DEF, "no_load"});
        vecs.push_back('{7'b0110011, 5'd4, 5'd1, 5'd4, 1, 0, 1, 1, S_LU,  "mem_ready_lu"});
        vecs.push_back('{7'b1100011, 5'd6, 5'd2, 5'd6, 1, 0, 0, 0, S_LU,  "branch_op_rs1"});
        vecs.push_back('{7'b0000011, 5'd2, 5'd8, 5'd8, 1, 0, 0, 0, S_DEF, "load_rs2_ignored"});
        vecs.push_back('{7'b0010011, 5'd1, 5'd2, 5'd0, 0, 1, 0, 0, S_BR,  "branch_only"});
        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].mr, vecs[i].rd,
                  vecs[i].br, vecs[i].mq, vecs[i].dr);
            chk(vecs[i].name, 32'(strb), 32'(vecs[i].exp));
            tick;
        end

        // Memory wait 3 cycles then ready, with a branch held frozen in EX.
        drive(1'b0, 7'b0010011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("wait_c1_strb", 32'(strb), 32'(S_STL));
        tick;
        for (int c = 2; c <= 3; c++) begin
            chk("wait_mid_strb", 32'(strb), 32'(S_STL));
            chk("wait_mid_state", 32'(ctrl_state), 32'd1);
            tick;
        end
        dmem_ready = 1'b1; #1;
        chk("wait_done_strb", 32'(strb), 32'(S_BR));
        chk("wait_done_state", 32'(ctrl_state), 32'd1);
        tick;
        idle(1'b0);
        chk("wait_after_state", 32'(ctrl_state), 32'd0);
        chk("wait_after_strb", 32'(strb), 32'(S_DEF));

        // Timeout: stuck memory reaches ERROR on cycle 5 and stays there.
        drive(1'b0, 7'b0010011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            chk("tmo_pre_err", 32'(mem_err), 32'd0);
            tick;
        end
        for (int c = 5; c <= 8; c++) begin
            if (c == 7) begin dmem_ready = 1'b1; mem_req = 1'b0; #1; end
            chk("tmo_state", 32'(ctrl_state), 32'd2);
            chk("tmo_err", 32'(mem_err), 32'd1);
            chk("tmo_strb", 32'(strb), 32'(S_KILL));
            tick;
        end
        idle(1'b1);
        chk("tmo_rst_err", 32'(mem_err), 32'd0);
        tick;
        idle(1'b0);
        chk("tmo_rst_state", 32'(ctrl_state), 32'd0);
        chk("tmo_rst_strb", 32'(strb), 32'(S_DEF));
        tick;

        // Reset mid-wait.
        drive(1'b0, 7'b0010011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); tick; tick;
        drive(1'b1, 7'b0010011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("rst_wait_strb", 32'(strb), 32'(S_KILL));
        tick;
        idle(1'b0);
        chk("rst_wait_next_state", 32'(ctrl_state), 32'd0);
        chk("rst_wait_next_strb", 32'(strb), 32'(S_DEF));

        // Randomized run against the reference model; start from a known reset.
        idle(1'b1); tick;
        m_mode = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
        for (int n = 0; n < 600; n++) begin
            logic [6:0] ops [8];
            ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                    7'b1100011, 7'b0110111, 7'b1101111, 7'b0010111};
            drive(($urandom_range(0, 39) == 0), ops[$urandom_range(0, 7)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
            model_step(es, ee, nm, nw);
            chk("rand_outputs", {22'd0, strb, ee ? 1'b1 : 1'b0, 2'(m_mode)},
                {22'd0, es, ee, 2'(m_mode)});
            chk("rand_outputs_dut", {22'd0, strb, mem_err, ctrl_state}, {22'd0, es, ee, 2'(m_mode)});
            if (rst) begin
                m_stalls = 0; m_flushes = 0;
            end else begin
                if (!es[6]) m_stalls++;
                if (es == S_BR) m_flushes++;
            end
            tick;
            m_mode = nm; m_waited = nw;
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
            chk("rand_stall_cycles", stall_cycles, 32'(m_stalls));
            chk("rand_flush_count", flush_count, 32'(m_flushes));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
